// File: rtl/usb_crc_pkg.sv
// rtl/usb_crc_pkg.sv - shared constants, state encoding and helpers for the USB CRC engine
package usb_crc_pkg;

    localparam logic [15:0] POLY16 = 16'h8005;
    localparam logic [4:0]  POLY5  = 5'h05;
    localparam logic [15:0] RES16  = 16'h800D;
    localparam logic [4:0]  RES5   = 5'h0C;
    localparam logic [15:0] INIT   = 16'hFFFF;

    // Append beat counter: CRC16 at one bit per beat needs 16 beats (index 0..15).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        APPEND = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Mirror a 16-bit word so the register MSB lands in bit 0 (first bit on the wire).
    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc_step.sv
// rtl/usb_crc_step.sv - one beat of CRC5/CRC16 update, DATA_W bits unrolled LSB-first
module usb_crc_step
    import usb_crc_pkg::*;
#(
    parameter int DATA_W = 1
)
(
    input  logic [15:0]       i_q,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_crc5,
    output logic [15:0]       o_q_next
);

    logic [15:0] w_q;
    logic        w_fb;

    // Shift each bit of the beat into the register, din[0] first; CRC5 lives in q[4:0].
    always_comb begin
        w_q  = i_q;
        w_fb = 1'b0;
        for (int b = 0; b < DATA_W; b++) begin
            if (i_crc5) begin
                w_fb = i_din[b] ^ w_q[4];
                w_q  = {11'b0, w_q[3:0], 1'b0} ^ (w_fb ? {11'b0, POLY5} : 16'h0000);
            end else begin
                w_fb = i_din[b] ^ w_q[15];
                w_q  = {w_q[14:0], 1'b0} ^ (w_fb ? POLY16 : 16'h0000);
            end
        end
        o_q_next = w_q;
    end

endmodule

// File: rtl/usb_crc_engine.sv
// rtl/usb_crc_engine.sv - USB CRC5/CRC16 generator (TX append) and checker (RX residual)
module usb_crc_engine
    import usb_crc_pkg::*;
#(
    parameter int DATA_W = 1
)
(
    input  logic              clk_c,
    input  logic              reset,
    input  logic              halt_tx,
    input  logic              start,
    input  logic              mode_tx,
    input  logic              crc5_sel,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic [15:0]       crc_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    if (!(DATA_W == 1 || DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : g_bad_width
        $error("usb_crc_engine: DATA_W must be 1, 2, 4 or 8");
    end

    localparam int NB16 = 16 / DATA_W;
    localparam int NB5  = (5 + DATA_W - 1) / DATA_W;
    localparam logic [CNT_W-1:0] LAST16 = CNT_W'(NB16 - 1);
    localparam logic [CNT_W-1:0] LAST5  = CNT_W'(NB5 - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [15:0]        r_q;
    logic [15:0]        w_q_next;
    logic               r_mode_tx;
    logic               r_crc5;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_dout;
    logic               r_dout_valid;
    logic               r_dout_last;
    logic               r_done;
    logic               r_error;
    logic               w_busy;
    logic [15:0]        w_rev;
    logic [15:0]        w_crc_out;
    logic [4:0]         w_shamt;
    logic [DATA_W-1:0]  w_crc_beat;
    logic               w_last_beat;

    usb_crc_step #(.DATA_W(DATA_W)) u_step (
        .i_q      (r_q),
        .i_din    (din),
        .i_crc5   (r_crc5),
        .o_q_next (w_q_next)
    );

    // Complemented, wire-order CRC; CRC5 bits come from q[4:0] only.
    assign w_rev       = bitrev16(r_q);
    assign w_crc_out   = r_crc5 ? {11'b0, ~w_rev[15:11]} : ~w_rev;
    assign w_shamt     = 5'(32'(r_cnt) * DATA_W);
    assign w_crc_beat  = DATA_W'(w_crc_out >> w_shamt);
    assign w_last_beat = (r_cnt == (r_crc5 ? LAST5 : LAST16));

    // State register.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: halt freezes, start restarts from any state.
    always_comb begin
        w_next_state = r_state;
        if (!halt_tx) begin
            if (start) begin
                w_next_state = ACCUM;
            end else begin
                case (r_state)
                    IDLE:    w_next_state = IDLE;
                    ACCUM:   if (din_valid && din_last) w_next_state = r_mode_tx ? APPEND : CHECK;
                    APPEND:  if (w_last_beat) w_next_state = DONE;
                    CHECK:   w_next_state = DONE;
                    DONE:    w_next_state = IDLE;
                    default: w_next_state = IDLE;
                endcase
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ACCUM, APPEND, CHECK: w_busy = 1'b1;
            default:              w_busy = 1'b0;
        endcase
    end

    // CRC register, append counter and registered outputs.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            r_q          <= INIT;
            r_mode_tx    <= 1'b0;
            r_crc5       <= 1'b0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else if (!halt_tx) begin
            if (start) begin
                r_q          <= INIT;
                r_mode_tx    <= mode_tx;
                r_crc5       <= crc5_sel;
                r_cnt        <= '0;
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                case (r_state)
                    ACCUM: begin
                        r_dout_valid <= din_valid;
                        r_dout_last  <= din_valid & din_last & ~r_mode_tx;
                        if (din_valid) begin
                            r_dout <= din;
                            r_q    <= w_q_next;
                        end
                    end
                    APPEND: begin
                        r_dout_valid <= 1'b1;
                        r_dout       <= w_crc_beat;
                        r_dout_last  <= w_last_beat;
                        r_cnt        <= r_cnt + CNT_W'(1);
                        if (w_last_beat) r_done <= 1'b1;
                    end
                    CHECK: begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        r_done       <= 1'b1;
                        r_error      <= r_crc5 ? (r_q[4:0] != RES5) : (r_q != RES16);
                    end
                    default: begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign dout_last  = r_dout_last;
    assign crc_out    = w_crc_out;
    assign busy       = w_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
